// File: rtl/live_audio_rx.sv
// Receive side of the live-audio path: pairs left/right channel words into stereo frames
// and buffers them in a show-ahead FIFO with a registered head.
//
// state  | meaning
// WAIT_L | expecting a left word (id=0)
// WAIT_R | left sample held, expecting the matching right word (id=1)
module live_audio_rx #(
    parameter int AUDIO_WIDTH  = 16,
    parameter int BUFFER_DEPTH = 4,
    parameter int SAMPLE_MSB   = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                audio_data,
    input  logic                       audio_id,
    input  logic                       audio_valid,
    output logic                       audio_ready,
    output logic [2*AUDIO_WIDTH-1:0]   data_out,
    input  logic                       rd_en,
    output logic                       empty,
    output logic [BUFFER_DEPTH:0]      level,
    output logic [7:0]                 sync_err_count
);

    localparam int DEPTH = 2 ** BUFFER_DEPTH;
    localparam logic [BUFFER_DEPTH:0] FULL_LEVEL = (BUFFER_DEPTH + 1)'(DEPTH);
    localparam logic [BUFFER_DEPTH:0] ONE_LEVEL  = (BUFFER_DEPTH + 1)'(1);

    typedef enum logic {WAIT_L, WAIT_R} state_t;

    state_t                    state, state_nxt;
    logic [AUDIO_WIDTH-1:0]    left_q, left_nxt, sample;
    logic [2*AUDIO_WIDTH-1:0]  wdata;
    logic [2*AUDIO_WIDTH-1:0]  mem [DEPTH];
    logic [BUFFER_DEPTH-1:0]   wr_ptr, rd_ptr, rd_next;
    logic                      ready_en, beat, push, pop, err_inc, full;

    assign sample   = audio_data[SAMPLE_MSB -: AUDIO_WIDTH];
    assign wdata    = {left_q, sample};
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    // ready_en holds the handshake off until the first edge after reset release
    assign audio_ready = ready_en & ~full;
    assign beat     = audio_valid & audio_ready;
    assign pop      = rd_en & ~empty;
    assign rd_next  = rd_ptr + 1'b1;

    always_comb begin
        state_nxt = state;
        left_nxt  = left_q;
        push      = 1'b0;
        err_inc   = 1'b0;
        if (beat) begin
            case (state)
                WAIT_L: begin
                    if (!audio_id) begin
                        left_nxt  = sample;
                        state_nxt = WAIT_R;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                WAIT_R: begin
                    if (audio_id) begin
                        push      = 1'b1;
                        state_nxt = WAIT_L;
                    end else begin
                        // resync to the newest left word
                        left_nxt = sample;
                        err_inc  = 1'b1;
                    end
                end
                default: state_nxt = WAIT_L;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_L;
            left_q         <= '0;
            ready_en       <= 1'b0;
            sync_err_count <= '0;
        end else begin
            state    <= state_nxt;
            left_q   <= left_nxt;
            ready_en <= 1'b1;
            if (err_inc && sync_err_count != 8'hFF)
                sync_err_count <= sync_err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_out <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   level <= level + ONE_LEVEL;
                2'b01:   level <= level - ONE_LEVEL;
                default: level <= level;
            endcase
            // head register: the new head comes from memory, or bypasses the write
            // when the FIFO would otherwise go empty or is empty now
            if (pop) begin
                if (level == ONE_LEVEL && push)
                    data_out <= wdata;
                else if (level != ONE_LEVEL)
                    data_out <= mem[rd_next];
            end else if (push && empty) begin
                data_out <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_live_audio_rx.sv
// Directed bench for live_audio_rx: a pairing model feeds a frame scoreboard that is
// checked against data_out on every pop.
module tb_live_audio_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] audio_data;
    logic        audio_id, audio_valid, audio_ready;
    logic [31:0] data_out;
    logic        rd_en, empty;
    logic [4:0]  level;
    logic [7:0]  sync_err_count;

    logic [31:0] b_audio_data;
    logic        b_audio_id, b_audio_valid, b_audio_ready;
    logic [31:0] b_data_out;
    logic        b_rd_en, b_empty;
    logic [4:0]  b_level;
    logic [7:0]  b_sync_err_count;

    int checks = 0;
    int errors = 0;

    logic        m_state;
    logic [15:0] m_left;
    int          m_err;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] held_r;

    always #5 clk = ~clk;

    live_audio_rx dut (
        .clk(clk), .reset(reset), .audio_data(audio_data), .audio_id(audio_id),
        .audio_valid(audio_valid), .audio_ready(audio_ready), .data_out(data_out),
        .rd_en(rd_en), .empty(empty), .level(level), .sync_err_count(sync_err_count)
    );

    live_audio_rx #(.AUDIO_WIDTH(16), .BUFFER_DEPTH(4), .SAMPLE_MSB(27)) dut_b (
        .clk(clk), .reset(reset), .audio_data(b_audio_data), .audio_id(b_audio_id),
        .audio_valid(b_audio_valid), .audio_ready(b_audio_ready), .data_out(b_data_out),
        .rd_en(b_rd_en), .empty(b_empty), .level(b_level), .sync_err_count(b_sync_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic id, input logic [31:0] d);
        logic [15:0] s;
        s = d[31:16];
        if (m_state == 1'b0) begin
            if (!id) begin m_left = s; m_state = 1'b1; end
            else if (m_err < 255) m_err++;
        end else begin
            if (id) begin exp_q.push_back({m_left, s}); m_state = 1'b0; end
            else begin m_left = s; if (m_err < 255) m_err++; end
        end
    endtask

    task automatic send_beat(input logic id, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        audio_valid = 1'b1;
        audio_id    = id;
        audio_data  = d;
        while (!audio_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("beat_timeout", {63'd0, audio_ready}, 64'd1);
        end else begin
            @(posedge clk);
            model_beat(id, d);
        end
        #1 audio_valid = 1'b0;
    endtask

    task automatic pop_frame(input string tag);
        logic [31:0] x;
        @(negedge clk);
        chk("empty_before_pop", {63'd0, empty}, 64'd0);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk(tag, {32'd0, data_out}, {32'd0, x});
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        audio_data = '0; audio_id = 1'b0; audio_valid = 1'b0; rd_en = 1'b0;
        b_audio_data = '0; b_audio_id = 1'b0; b_audio_valid = 1'b0; b_rd_en = 1'b0;
        m_state = 1'b0; m_left = '0; m_err = 0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, audio_ready}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_level", {59'd0, level}, 64'd0);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_err", {56'd0, sync_err_count}, 64'd0);
        chk("rst_b_ready", {63'd0, b_audio_ready}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_release", {63'd0, audio_ready}, 64'd1);

        // basic frame
        send_beat(1'b0, 32'h12340000);
        send_beat(1'b1, 32'hABCD0000);
        @(negedge clk);
        chk("basic_empty", {63'd0, empty}, 64'd0);
        chk("basic_level", {59'd0, level}, 64'd1);
        chk("basic_data", {32'd0, data_out}, 64'h1234ABCD);
        pop_frame("basic_pop");
        @(negedge clk);
        chk("basic_empty_after", {63'd0, empty}, 64'd1);
        chk("basic_level_after", {59'd0, level}, 64'd0);

        // sample field at SAMPLE_MSB=27
        @(negedge clk);
        chk("b_ready", {63'd0, b_audio_ready}, 64'd1);
        b_audio_valid = 1'b1; b_audio_id = 1'b0; b_audio_data = 32'h0FFFF000;
        @(posedge clk);
        #1 b_audio_id = 1'b1; b_audio_data = 32'h08000000;
        @(posedge clk);
        #1 b_audio_valid = 1'b0;
        @(negedge clk);
        chk("field_empty", {63'd0, b_empty}, 64'd0);
        chk("field_data", {32'd0, b_data_out}, 64'hFFFF8000);

        // channel-order errors
        send_beat(1'b1, 32'hAAAA0000);
        send_beat(1'b1, 32'hBBBB0000);
        send_beat(1'b0, 32'h11110000);
        send_beat(1'b0, 32'h22220000);
        send_beat(1'b1, 32'h77770000);
        @(negedge clk);
        chk("order_err", {56'd0, sync_err_count}, 64'd3);
        chk("order_level", {59'd0, level}, 64'd1);
        chk("order_left", {48'd0, data_out[31:16]}, 64'h2222);
        pop_frame("order_pop");
        for (int i = 0; i < 300; i++) send_beat(1'b1, $urandom);
        @(negedge clk);
        chk("err_saturate", {56'd0, sync_err_count}, 64'd255);
        chk("err_model", {56'd0, sync_err_count}, 64'(m_err));
        chk("err_empty", {63'd0, empty}, 64'd1);

        // full / back-pressure
        for (int i = 0; i < 16; i++) begin
            send_beat(1'b0, $urandom);
            send_beat(1'b1, $urandom);
        end
        @(negedge clk);
        chk("full_level", {59'd0, level}, 64'd16);
        chk("full_ready", {63'd0, audio_ready}, 64'd0);
        audio_valid = 1'b1; audio_id = 1'b0; audio_data = 32'h5A5A0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("held_level", {59'd0, level}, 64'd16);
            chk("held_ready", {63'd0, audio_ready}, 64'd0);
        end
        e = exp_q.pop_front();
        chk("full_pop_data", {32'd0, data_out}, {32'd0, e});
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", {63'd0, audio_ready}, 64'd1);
        chk("level_after_pop", {59'd0, level}, 64'd15);
        @(posedge clk);
        model_beat(1'b0, 32'h5A5A0000);
        #1 audio_valid = 1'b0;
        @(negedge clk);
        chk("held_accepted_level", {59'd0, level}, 64'd15);
        send_beat(1'b1, 32'hC3C30000);
        @(negedge clk);
        chk("refill_level", {59'd0, level}, 64'd16);
        for (int i = 0; i < 16; i++) pop_frame("drain_order");
        @(negedge clk);
        chk("drain_empty", {63'd0, empty}, 64'd1);

        // simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) begin
            send_beat(1'b0, $urandom);
            send_beat(1'b1, $urandom);
        end
        send_beat(1'b0, 32'h0F0F0000);
        @(negedge clk);
        chk("sim_level_before", {59'd0, level}, 64'd5);
        held_r = 32'hF0F00000;
        audio_valid = 1'b1; audio_id = 1'b1; audio_data = held_r;
        e = exp_q.pop_front();
        chk("sim_head", {32'd0, data_out}, {32'd0, e});
        rd_en = 1'b1;
        @(posedge clk);
        model_beat(1'b1, held_r);
        #1 audio_valid = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("sim_level", {59'd0, level}, 64'd5);
        chk("sim_next_head", {32'd0, data_out}, {32'd0, exp_q[0]});
        for (int i = 0; i < 5; i++) pop_frame("sim_drain");
        @(negedge clk);
        chk("sim_last_empty", {63'd0, empty}, 64'd1);

        // underflow
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        chk("under_level", {59'd0, level}, 64'd0);
        chk("under_empty", {63'd0, empty}, 64'd1);

        // reset mid-frame
        send_beat(1'b1, 32'h99990000);
        send_beat(1'b0, 32'h13570000);
        send_beat(1'b1, 32'h24680000);
        send_beat(1'b0, 32'h55550000);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_ready", {63'd0, audio_ready}, 64'd0);
        chk("async_level", {59'd0, level}, 64'd0);
        chk("async_empty", {63'd0, empty}, 64'd1);
        chk("async_data", {32'd0, data_out}, 64'd0);
        chk("async_err", {56'd0, sync_err_count}, 64'd0);
        m_state = 1'b0; m_err = 0; exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        send_beat(1'b1, 32'h66660000);
        @(negedge clk);
        chk("midframe_err", {56'd0, sync_err_count}, 64'd1);
        chk("midframe_empty", {63'd0, empty}, 64'd1);
        chk("midframe_model", {56'd0, sync_err_count}, 64'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
